// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional one-entry skid buffer,
// stall hold, flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              w_rdy_eff;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_free;

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [ADDR_W-1:0] r_m_rd;
  logic [CTRL_W-1:0] r_m_ctrl;

  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [ADDR_W-1:0] r_s_rd;
  logic [CTRL_W-1:0] r_s_ctrl;

  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_rdy_eff   = out_ready_i & ~stall_i;
  assign w_out_fire  = r_m_valid & w_rdy_eff;
  assign w_main_free = ~r_m_valid | w_out_fire;
  assign w_in_fire   = in_valid_i & in_ready_o;

  // With a skid entry the ready is purely register driven; without one it is a
  // combinational pass-through of downstream readiness.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready_o = ~r_s_valid;
    end else begin : g_no_skid
      assign in_ready_o = w_main_free;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_rd    <= '0;
      r_m_ctrl  <= '0;
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_rd    <= '0;
      r_s_ctrl  <= '0;
    end else if (flush_i) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_main_free) begin
      // Skid always drains ahead of new input; in_ready is low while it is held.
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_data  <= r_s_data;
        r_m_rd    <= r_s_rd;
        r_m_ctrl  <= r_s_ctrl;
        r_s_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_m_valid <= 1'b1;
        r_m_data  <= data_i;
        r_m_rd    <= rd_i;
        r_m_ctrl  <= ctrl_i;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if ((SKID != 0) && w_in_fire) begin
      r_s_valid <= 1'b1;
      r_s_data  <= data_i;
      r_s_rd    <= rd_i;
      r_s_ctrl  <= ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !w_rdy_eff && !flush_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid_o = r_m_valid;
  assign data_o      = r_m_data;
  assign rd_o        = r_m_rd;
  assign ctrl_o      = r_m_ctrl & {CTRL_W{r_m_valid}};
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: SKID=0/CNT_W=16 and SKID=1/CNT_W=4 instances
// share stimulus and are each compared against a FIFO-level model every cycle.
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 5;
  localparam int PW = DW + AW + CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, stall, in_valid, out_ready;
  logic [DW-1:0] din;
  logic [AW-1:0] rin;
  logic [CW-1:0] cin;

  logic          ir0, ov0, ir1, ov1;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] r0, r1;
  logic [CW-1:0] c0, c1;
  logic [15:0]   sc0;
  logic [3:0]    sc1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: instance k is a FIFO of depth (k ? 2 : 1); head is the output entry.
  logic [PW-1:0] mq    [2][2];
  int            mn    [2];
  logic [PW-1:0] mlast [2];
  int            mcnt  [2];

  pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(ir0), .data_i(din), .rd_i(rin), .ctrl_i(cin),
    .out_valid_o(ov0), .out_ready_i(out_ready), .data_o(d0), .rd_o(r0), .ctrl_o(c0),
    .stall_cnt_o(sc0)
  );

  pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(ir1), .data_i(din), .rd_i(rin), .ctrl_i(cin),
    .out_valid_o(ov1), .out_ready_i(out_ready), .data_o(d1), .rd_o(r1), .ctrl_o(c1),
    .stall_cnt_o(sc1)
  );

  function automatic int cnt_max(input int k);
    return (k == 1) ? 15 : 65535;
  endfunction

  function automatic bit model_ready(input int k);
    if (k == 1) return mn[1] < 2;
    return (mn[0] == 0) || (out_ready && !stall);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic ir, input logic ov, input logic [DW-1:0] d,
                            input logic [AW-1:0] r, input logic [CW-1:0] c,
                            input logic [15:0] cnt);
    logic [PW-1:0] p;
    logic [CW-1:0] exp_c;
    p     = mlast[k];
    exp_c = (mn[k] > 0) ? p[CW-1:0] : '0;
    chk($sformatf("i%0d.in_ready", k), 64'(ir), 64'(model_ready(k)));
    chk($sformatf("i%0d.out_valid", k), 64'(ov), 64'(mn[k] > 0));
    chk($sformatf("i%0d.data", k), d, p[PW-1 -: DW]);
    chk($sformatf("i%0d.rd", k), 64'(r), 64'(p[CW +: AW]));
    chk($sformatf("i%0d.ctrl", k), 64'(c), 64'(exp_c));
    chk($sformatf("i%0d.stall_cnt", k), 64'(cnt), 64'(mcnt[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, ir0, ov0, d0, r0, c0, sc0);
      check_inst(1, ir1, ov1, d1, r1, c1, {12'd0, sc1});
    end
  end

  // Advance model and DUT by one clock edge using the inputs currently driven.
  task automatic tick();
    logic [PW-1:0] nq [2][2];
    int            nn [2];
    logic [PW-1:0] nl [2];
    int            nc [2];
    logic [PW-1:0] pin;
    bit            rdy, infire, outfire;
    pin = {din, rin, cin};
    rdy = out_ready && !stall;
    for (int k = 0; k < 2; k++) begin
      nq[k][0] = mq[k][0];
      nq[k][1] = mq[k][1];
      nn[k]    = mn[k];
      nl[k]    = mlast[k];
      nc[k]    = mcnt[k];
      infire   = in_valid && model_ready(k);
      outfire  = (mn[k] > 0) && rdy;
      if (rst) begin
        nn[k] = 0;
        nl[k] = '0;
        nc[k] = 0;
      end else begin
        if ((mn[k] > 0) && !rdy && !flush && (mcnt[k] < cnt_max(k))) nc[k] = mcnt[k] + 1;
        if (flush) begin
          nn[k] = 0;
        end else begin
          if (outfire) begin
            nq[k][0] = nq[k][1];
            nn[k]--;
          end
          if (infire) begin
            nq[k][nn[k]] = pin;
            nn[k]++;
          end
          if (nn[k] > 0) nl[k] = nq[k][0];
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mq[k][0] = nq[k][0];
      mq[k][1] = nq[k][1];
      mn[k]    = nn[k];
      mlast[k] = nl[k];
      mcnt[k]  = nc[k];
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] r,
                       input logic [CW-1:0] c);
    in_valid = v;
    din      = d;
    rin      = r;
    cin      = c;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mq[k][0] = '0;
      mq[k][1] = '0;
      mn[k]    = 0;
      mlast[k] = '0;
      mcnt[k]  = 0;
    end
    rst = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    do_reset();
    chk_en = 1'b1;
    chk("reset.ir0", 64'(ir0), 64'd1);
    chk("reset.ir1", 64'(ir1), 64'd1);
    chk("reset.ov1", 64'(ov1), 64'd0);
    chk("reset.d1", d1, 64'd0);
    chk("reset.c0", 64'(c0), 64'd0);

    // Full-throughput stream 1..8.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), AW'(i), '0);
      tick();
      chk("stream.d0", d0, 64'(i));
      chk("stream.d1", d1, 64'(i));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stream.cnt1", 64'(sc1), 64'd0);

    // Skid capture under a 3-cycle stall, then ordered release A, B, C.
    do_reset();
    drive(1'b1, 64'hA, 5'd1, 5'd1);
    tick();
    chk("skid.A", d1, 64'hA);
    drive(1'b1, 64'hB, 5'd2, 5'd2);
    stall = 1'b1;
    tick();
    chk("skid.ir_low", 64'(ir1), 64'd0);
    drive(1'b1, 64'hC, 5'd3, 5'd3);
    tick();
    tick();
    chk("skid.ir_held", 64'(ir1), 64'd0);
    chk("skid.cnt3", 64'(sc1), 64'd3);
    stall = 1'b0;
    tick();
    chk("skid.B", d1, 64'hB);
    chk("skid.ir_back", 64'(ir1), 64'd1);
    tick();
    chk("skid.C", d1, 64'hC);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("skid.drained", 64'(ov1), 64'd0);
    chk("skid.cnt_end", 64'(sc1), 64'd3);

    // Flush with both entries held and C offered in the same cycle.
    do_reset();
    stall = 1'b1;
    drive(1'b1, 64'h1A, 5'd4, 5'h1f);
    tick();
    drive(1'b1, 64'h1B, 5'd5, 5'h1f);
    tick();
    stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 64'h1C, 5'd6, 5'h1f);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush.ov1", 64'(ov1), 64'd0);
    chk("flush.c1", 64'(c1), 64'd0);
    chk("flush.ov0", 64'(ov0), 64'd0);
    chk("flush.c0", 64'(c0), 64'd0);
    tick();
    chk("flush.noC0", 64'(ov0), 64'd0);
    chk("flush.noC1", 64'(ov1), 64'd0);

    // Bubble masks ctrl while rd keeps its last value.
    do_reset();
    drive(1'b1, 64'h55, 5'd7, 5'h1f);
    tick();
    chk("bubble.ctrl_on", 64'(c1), 64'h1f);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bubble.ctrl_off", 64'(c1), 64'h0);
    chk("bubble.rd_held", 64'(r1), 64'd7);
    chk("bubble.data_held", d1, 64'h55);

    // Counter saturation at 15 for CNT_W=4; 20 for CNT_W=16.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 64'h77, 5'd8, 5'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    repeat (20) tick();
    chk("sat.cnt1", 64'(sc1), 64'd15);
    chk("sat.cnt0", 64'(sc0), 64'd20);
    do_reset();
    chk("sat.rst1", 64'(sc1), 64'd0);
    chk("sat.rst0", 64'(sc0), 64'd0);

    // SKID=0 combinational ready and simultaneous replacement.
    drive(1'b1, 64'h88, 5'd9, 5'd2);
    tick();
    drive(1'b1, 64'h99, 5'd10, 5'd3);
    @(negedge clk);
    chk("noskid.ir_low", 64'(ir0), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("noskid.ir_high", 64'(ir0), 64'd1);
    tick();
    chk("noskid.replace", d0, 64'h99);
    chk("noskid.valid", 64'(ov0), 64'd1);

    // Randomised traffic.
    repeat (3000) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 6) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, AW'($urandom), CW'($urandom));
      tick();
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage core, succeeding the fixed-width EX/MEM latch. It carries a data payload, a destination register address and a control bundle across one stage. It adds a valid/ready handshake with an optional one-entry skid buffer, a stall hold, a flush that inserts a bubble, and a saturating back-pressure cycle counter. It is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) by choosing widths.

## Interface
- DATA_W, 64: payload width (e.g. ALU result plus store data concatenated).
- ADDR_W, 5: destination register address width.
- CTRL_W, 5: control bundle width (MemToReg, RegWrite, MemWrite, MemRead, ExtOp, ...).
- SKID, 1: 1 = include skid entry (registered in_ready_o); 0 = single entry, combinational in_ready_o.
- CNT_W, 16: stall counter width.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held entries at next edge.
- stall_i  in  1  hold stage contents; forces effective downstream ready low.
- in_valid_i  in  1  upstream entry present.
- in_ready_o  out  1  stage accepts an entry this cycle.
- data_i / rd_i / ctrl_i  in  DATA_W / ADDR_W / CTRL_W  upstream payload.
- out_valid_o  out  1  output entry present.
- out_ready_i  in  1  downstream accepts.
- data_o / rd_o / ctrl_o  out  DATA_W / ADDR_W / CTRL_W  output payload.
- stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- rdy_eff = out_ready_i & ~stall_i. Input handshake: in_fire = in_valid_i & in_ready_o. Output handshake: out_fire = out_valid_o & rdy_eff.
- State: main entry (m_valid, m_data, m_rd, m_ctrl); if SKID=1, a skid entry (s_valid, s_*).
- SKID=1: in_ready_o = ~s_valid (register-driven only).
  - Main empty or out_fire: main loads skid if s_valid, else the input if in_fire, else m_valid clears. s_valid clears when skid moves to main. If skid moves and in_fire occurs in the same cycle, the input goes to skid. This cannot happen, because in_ready_o=0 while s_valid.
  - Main full and no out_fire: an in_fire entry goes to skid (s_valid=1).
- SKID=0: in_ready_o = ~m_valid | rdy_eff. Main loads the input on in_fire. Otherwise m_valid clears on out_fire.
- Order is preserved: skid contents always leave before any later input.
- flush_i=1: m_valid and s_valid both become 0 at the edge. Any same-cycle in_fire entry is dropped. Payload registers are not required to change. in_ready_o still follows its rule during the flush cycle (the upstream handshake completes, and the entry is discarded).
- flush_i and stall_i together: the flush wins.
- ctrl_o = m_ctrl & {CTRL_W{m_valid}}, so a bubble never asserts RegWrite/MemWrite/MemRead. data_o and rd_o show the raw main registers regardless of valid.
- out_valid_o = m_valid.
- stall_cnt_o increments by 1 each cycle with m_valid & ~rdy_eff & ~flush_i. It saturates at 2^CNT_W-1 and does not wrap. It is cleared only by rst_i.

## Timing
- Reset (rst_i=1 at edge): m_valid=0, s_valid=0, all payload registers 0, stall_cnt_o=0. After reset: out_valid_o=0, ctrl_o=0, data_o=0, rd_o=0. in_ready_o=1 (both SKID values).
- rst_i overrides flush_i, stall_i and all handshakes in the same cycle. Reset mid-stream loses both entries.
- Latency: an input accepted at edge N appears on the outputs after edge N. Accepting a new input at edge N+1 gives one entry per cycle at full throughput.
- SKID=1: accepts exactly one extra entry after downstream stops. in_ready_o drops the cycle after that capture.
- Stall release: with skid full, the first edge with rdy_eff=1 moves skid to main. in_ready_o returns to 1 after that edge.

## Test plan
- Reset, then stream data 1..8 with out_ready_i=1 and stall_i=0 -> outputs 1..8 on consecutive cycles, 1-cycle latency, stall_cnt_o=0.
- SKID=1: main holds A; in the cycle B is presented, stall_i goes 1 for 3 cycles -> B captured in skid, in_ready_o=0 for the rest of the stall. On release, A then B then C in order. stall_cnt_o=3.
- Flush with main and skid full, plus in_fire of C in the same cycle -> next cycle out_valid_o=0, ctrl_o=0. C never appears.
- ctrl_i=5'b11111 on an accepted entry, then a bubble cycle -> ctrl_o=5'b11111, then 5'b00000, while rd_o holds its last value.
- CNT_W=4 with out_ready_i held 0 for 20 cycles and main valid -> stall_cnt_o saturates at 15. rst_i returns it to 0.
- SKID=0: out_ready_i=0 with main full -> in_ready_o=0 in the same cycle. Raising out_ready_i gives in_ready_o=1 combinationally, with simultaneous replacement.
